// File: rtl/wdt_supervisor_if.sv
// wdt_supervisor_if: heartbeat/control inputs and status outputs of the watchdog supervisor.
// Parameters must match those of the wdt_supervisor instance it connects to.
interface wdt_supervisor_if #(
   parameter int NUM_TASKS  = 4,
   parameter int PERIOD     = 30,
   parameter int MAX_RESETS = 3
);
   logic                              i_enable;
   logic [NUM_TASKS-1:0]              i_heartbeat;
   logic                              i_clear_fault;
   logic                              o_kick;
   logic                              o_sys_reset;
   logic                              o_lockout;
   logic [NUM_TASKS-1:0]              o_pending;
   logic [$clog2(PERIOD+1)-1:0]       o_count;
   logic [$clog2(MAX_RESETS+1)-1:0]   o_fail_count;
   modport master (
      output i_enable, i_heartbeat, i_clear_fault,
      input  o_kick, o_sys_reset, o_lockout, o_pending, o_count, o_fail_count
   );
   modport slave (
      input  i_enable, i_heartbeat, i_clear_fault,
      output o_kick, o_sys_reset, o_lockout, o_pending, o_count, o_fail_count
   );
endinterface

// File: rtl/wdt_supervisor.sv
// wdt_supervisor: multi-task watchdog; kicks when all tasks check in per window,
// sequences a timed system reset on timeout and latches lockout after MAX_RESETS failures.
module wdt_supervisor #(
   parameter int NUM_TASKS   = 4,
   parameter int PERIOD      = 30,
   parameter int HOLD_CYCLES = 8,
   parameter int MAX_RESETS  = 3
) (
   input logic              i_clk,
   input logic              i_rst,
   wdt_supervisor_if.slave  bus
);
   localparam int CW = $clog2(PERIOD+1);
   localparam int FW = $clog2(MAX_RESETS+1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LP_PERIOD = CW'(PERIOD);
   localparam logic [FW-1:0] LP_MAX    = FW'(MAX_RESETS);
   localparam logic [HW-1:0] LP_HOLD   = HW'(HOLD_CYCLES-1);
   typedef enum logic [1:0] {IDLE, RUN, HOLD, LOCKOUT} state_t;
   state_t               r_state, w_state_nx;
   logic [CW-1:0]        r_count, w_count_nx;
   logic [NUM_TASKS-1:0] r_seen, w_seen_nx, w_seen_all;
   logic [FW-1:0]        r_fail, w_fail_nx;
   logic [HW-1:0]        r_hold, w_hold_nx;
   logic                 r_kick, w_kick_nx;
   logic                 w_done;
   assign w_seen_all = r_seen | bus.i_heartbeat;
   assign w_done     = &w_seen_all;
   always_comb begin
      w_state_nx = r_state;
      w_count_nx = r_count;
      w_seen_nx  = r_seen;
      w_fail_nx  = r_fail;
      w_hold_nx  = r_hold;
      w_kick_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            w_count_nx = LP_PERIOD;
            w_seen_nx  = '0;
            w_state_nx = bus.i_enable ? RUN : IDLE;
         end
         RUN: begin
            // completion outranks the count==0 timeout on the same edge
            if (!bus.i_enable) begin
               w_state_nx = IDLE;
               w_count_nx = LP_PERIOD;
               w_seen_nx  = '0;
            end else if (w_done) begin
               w_kick_nx  = 1'b1;
               w_count_nx = LP_PERIOD;
               w_seen_nx  = '0;
               w_fail_nx  = '0;
            end else if (r_count != '0) begin
               w_count_nx = r_count - CW'(1);
               w_seen_nx  = w_seen_all;
            end else begin
               w_state_nx = HOLD;
               w_seen_nx  = '0;
               w_hold_nx  = LP_HOLD;
               w_fail_nx  = (r_fail == LP_MAX) ? r_fail : r_fail + FW'(1);
            end
         end
         HOLD: begin
            if (r_hold != '0) begin
               w_hold_nx = r_hold - HW'(1);
            end else if (r_fail == LP_MAX) begin
               w_state_nx = LOCKOUT;
            end else begin
               w_state_nx = RUN;
               w_count_nx = LP_PERIOD;
               w_seen_nx  = '0;
            end
         end
         LOCKOUT: begin
            if (bus.i_clear_fault) begin
               w_state_nx = IDLE;
               w_fail_nx  = '0;
               w_count_nx = LP_PERIOD;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_count <= LP_PERIOD;
         r_seen  <= '0;
         r_fail  <= '0;
         r_hold  <= '0;
         r_kick  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_count <= w_count_nx;
         r_seen  <= w_seen_nx;
         r_fail  <= w_fail_nx;
         r_hold  <= w_hold_nx;
         r_kick  <= w_kick_nx;
      end
   end
   assign bus.o_kick       = r_kick;
   assign bus.o_sys_reset  = (r_state == HOLD) || (r_state == LOCKOUT);
   assign bus.o_lockout    = (r_state == LOCKOUT);
   assign bus.o_pending    = (r_state == RUN) ? ~r_seen : '0;
   assign bus.o_count      = r_count;
   assign bus.o_fail_count = r_fail;
endmodule

// File: tb/tb_wdt_supervisor.sv
// tb_wdt_supervisor: directed stimulus pushes cycle-stamped expected snapshots into a
// scoreboard; an independent monitor compares them when the cycle (or an async probe) arrives.
module tb_wdt_supervisor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   kicks = 0;
   int   tests = 0;
   int   fails = 0;
   bit   stim_done = 1'b0;
   event ev_probe;
   typedef struct {
      int         c;
      string      name;
      logic [3:0] pend;
      logic       kick;
      logic       srst;
      logic       lock;
      logic [4:0] cnt;
      logic [1:0] fc;
   } exp_t;
   exp_t sb[$];
   wdt_supervisor_if bus ();
   wdt_supervisor dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.o_kick) kicks <= kicks + 1;
   function automatic void push_exp(int c, string n, logic [3:0] p, logic k, logic s,
                                    logic l, logic [4:0] ct, logic [1:0] f);
      exp_t e;
      e.c = c; e.name = n; e.pend = p; e.kick = k; e.srst = s; e.lock = l; e.cnt = ct; e.fc = f;
      sb.push_back(e);
   endfunction
   task automatic go_to(int t);
      while (cyc < t) @(negedge clk);
   endtask
   task automatic pulse(int t, logic [3:0] v);
      go_to(t);
      bus.i_heartbeat = v;
      go_to(t + 1);
      bus.i_heartbeat = 4'b0000;
   endtask
   initial begin
      forever begin
         @(negedge clk or ev_probe);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == cyc) begin
               tests++;
               if ({bus.o_pending, bus.o_kick, bus.o_sys_reset, bus.o_lockout, bus.o_count, bus.o_fail_count} !==
                   {sb[i].pend, sb[i].kick, sb[i].srst, sb[i].lock, sb[i].cnt, sb[i].fc}) begin
                  fails++;
                  $display("FAIL %s cyc=%0d got pend=%b kick=%b srst=%b lock=%b cnt=%0d fc=%0d exp pend=%b kick=%b srst=%b lock=%b cnt=%0d fc=%0d",
                           sb[i].name, cyc, bus.o_pending, bus.o_kick, bus.o_sys_reset, bus.o_lockout,
                           bus.o_count, bus.o_fail_count, sb[i].pend, sb[i].kick, sb[i].srst, sb[i].lock,
                           sb[i].cnt, sb[i].fc);
               end
               sb.delete(i);
            end
         end
         if (stim_done) begin
            tests++;
            if (sb.size() != 0) begin
               fails++;
               $display("FAIL unchecked_expectations got %0d left exp 0", sb.size());
            end
            tests++;
            if (kicks != 4) begin
               fails++;
               $display("FAIL kick_total got %0d exp 4", kicks);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL global_timeout got cyc=%0d exp finish", cyc);
      $fatal(1);
   end
   initial begin
      int b, l2, m, s0;
      bus.i_enable = 1'b0;
      bus.i_heartbeat = 4'b0000;
      bus.i_clear_fault = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push_exp(cyc + 1, "reset", 4'h0, 0, 0, 0, 5'd30, 2'd0);
      go_to(cyc + 1);
      // staggered completion
      bus.i_enable = 1'b1;
      b = cyc + 1;
      push_exp(b,      "t2_entry", 4'b1111, 0, 0, 0, 5'd30, 2'd0);
      push_exp(b + 5,  "t2_bit0",  4'b1110, 0, 0, 0, 5'd25, 2'd0);
      push_exp(b + 10, "t2_bit1",  4'b1100, 0, 0, 0, 5'd20, 2'd0);
      push_exp(b + 15, "t2_bit2",  4'b1000, 0, 0, 0, 5'd15, 2'd0);
      push_exp(b + 20, "t2_kick",  4'b1111, 1, 0, 0, 5'd30, 2'd0);
      push_exp(b + 21, "t2_after", 4'b1111, 0, 0, 0, 5'd29, 2'd0);
      pulse(b + 4,  4'b0001);
      pulse(b + 9,  4'b0010);
      pulse(b + 14, 4'b0100);
      pulse(b + 19, 4'b1000);
      // simultaneous heartbeats
      b = b + 20;
      push_exp(b + 3, "t3_sim_kick",  4'b1111, 1, 0, 0, 5'd30, 2'd0);
      push_exp(b + 4, "t3_sim_after", 4'b1111, 0, 0, 0, 5'd29, 2'd0);
      pulse(b + 2, 4'b1111);
      // completion on the count==0 edge
      b = b + 3;
      push_exp(b + 30, "t3_cnt0",       4'b1000, 0, 0, 0, 5'd0,  2'd0);
      push_exp(b + 31, "t3_edge_kick",  4'b1111, 1, 0, 0, 5'd30, 2'd0);
      push_exp(b + 32, "t3_edge_after", 4'b1111, 0, 0, 0, 5'd29, 2'd0);
      pulse(b + 4,  4'b0111);
      pulse(b + 30, 4'b1000);
      // partial check-in -> one timeout
      b = b + 31;
      push_exp(b + 30, "t4_cnt0",     4'b1000, 0, 0, 0, 5'd0,  2'd0);
      push_exp(b + 31, "t4_timeout",  4'b0000, 0, 1, 0, 5'd0,  2'd1);
      push_exp(b + 38, "t4_hold_end", 4'b0000, 0, 1, 0, 5'd0,  2'd1);
      push_exp(b + 39, "t4_resume",   4'b1111, 0, 0, 0, 5'd30, 2'd1);
      pulse(b + 2,  4'b0111);
      pulse(b + 33, 4'b1111);
      b = b + 39;
      push_exp(b + 1, "t4_run",     4'b1111, 0, 0, 0, 5'd29, 2'd1);
      push_exp(b + 2, "t4_recover", 4'b1111, 1, 0, 0, 5'd30, 2'd0);
      pulse(b + 1, 4'b1111);
      // three silent windows -> lockout
      b = b + 2;
      for (int i = 0; i < 3; i++) begin
         push_exp(b + 39*i + 31, "t5_timeout", 4'b0000, 0, 1, 0, 5'd0, 2'(i + 1));
         if (i < 2) push_exp(b + 39*i + 39, "t5_rerun", 4'b1111, 0, 0, 0, 5'd30, 2'(i + 1));
      end
      l2 = b + 78;
      push_exp(l2 + 38, "t5_last_hold", 4'b0000, 0, 1, 0, 5'd0,  2'd3);
      push_exp(l2 + 39, "t5_lock",      4'b0000, 0, 1, 1, 5'd0,  2'd3);
      push_exp(l2 + 46, "t5_locked",    4'b0000, 0, 1, 1, 5'd0,  2'd3);
      push_exp(l2 + 51, "t5_clear",     4'b0000, 0, 0, 0, 5'd30, 2'd0);
      push_exp(l2 + 52, "t5_idle",      4'b0000, 0, 0, 0, 5'd30, 2'd0);
      go_to(l2 + 40);
      bus.i_enable = 1'b0;
      go_to(l2 + 41);
      bus.i_heartbeat = 4'b1111;
      go_to(l2 + 43);
      bus.i_enable = 1'b1;
      bus.i_heartbeat = 4'b0000;
      go_to(l2 + 50);
      bus.i_enable = 1'b0;
      bus.i_clear_fault = 1'b1;
      go_to(l2 + 51);
      bus.i_clear_fault = 1'b0;
      // async reset mid-HOLD
      m = l2 + 52;
      go_to(m);
      bus.i_enable = 1'b1;
      s0 = m + 1;
      push_exp(s0 + 32, "t6_hold",   4'b0000, 0, 1, 0, 5'd0,  2'd1);
      push_exp(s0 + 34, "t6_in_rst", 4'b0000, 0, 0, 0, 5'd30, 2'd0);
      push_exp(s0 + 36, "t6_idle",   4'b0000, 0, 0, 0, 5'd30, 2'd0);
      push_exp(s0 + 37, "t6_idle2",  4'b0000, 0, 0, 0, 5'd30, 2'd0);
      go_to(s0 + 33);
      bus.i_enable = 1'b0;
      #2 rst = 1'b1;
      #1 push_exp(cyc, "t6_async", 4'b0000, 0, 0, 0, 5'd30, 2'd0);
      -> ev_probe;
      go_to(s0 + 35);
      rst = 1'b0;
      go_to(s0 + 38);
      #1 stim_done = 1'b1;
      -> ev_probe;
   end
endmodule

// File: doc/wdt_supervisor.md
# wdt_supervisor

Multi-task watchdog supervisor. It collects heartbeat pulses from NUM_TASKS software or hardware requesters and issues a watchdog kick only when every task has checked in within the current window. On timeout it sequences a timed system reset, counts consecutive failures, and enters a latched lockout after MAX_RESETS consecutive timeouts. It sits between the task heartbeat sources and the system reset network, and contains its own countdown.

## Interface
- NUM_TASKS, 4: number of heartbeat requesters (1..16).
- PERIOD, 30: window length in cycles; countdown reload value.
- HOLD_CYCLES, 8: cycles sys_reset is held per timeout (>=1).
- MAX_RESETS, 3: consecutive timeouts that cause lockout (>=1).
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  arms the supervisor (IDLE -> RUN).
- heartbeat  in  NUM_TASKS  per-task check-in; a bit is sampled high on any edge in RUN.
- clear_fault  in  1  releases LOCKOUT.
- kick  out  1  one-cycle pulse on a completed window.
- sys_reset  out  1  system reset request.
- lockout  out  1  latched fatal-fault flag.
- pending  out  NUM_TASKS  tasks not yet seen this window; all-zero outside RUN.
- count  out  $clog2(PERIOD+1)  current countdown value.
- fail_count  out  $clog2(MAX_RESETS+1)  consecutive timeouts; saturates at MAX_RESETS.

## Operation
- The supervisor has four states: IDLE, RUN, HOLD and LOCKOUT. All outputs are registered.
- Reset behaviour: state=IDLE, count=PERIOD, seen=0, fail_count=0, kick=sys_reset=lockout=0.
- IDLE:
  - count=PERIOD, seen=0.
  - enable=1 -> RUN.
- RUN:
  - Each edge, seen <= seen | heartbeat.
  - done = ((seen | heartbeat) == all-ones).
  - Priority order at each edge:
    1. enable=0 -> IDLE. No kick. fail_count is kept.
    2. done -> kick=1 for one cycle, count=PERIOD, seen=0, fail_count=0.
    3. count>0 -> count-1.
    4. count==0 -> timeout: HOLD, sys_reset=1, fail_count+1 (saturating), seen=0.
  - If done and count==0 occur in the same cycle, the kick wins and no timeout occurs.
- HOLD:
  - heartbeat and enable are ignored; sys_reset=1.
  - An internal hold counter is loaded with HOLD_CYCLES-1 and decrements each cycle.
  - When it reaches 0, at the next edge:
    - if fail_count==MAX_RESETS -> LOCKOUT;
    - otherwise -> RUN with count=PERIOD and sys_reset=0.
- LOCKOUT:
  - sys_reset=1, lockout=1; heartbeat and enable are ignored.
  - clear_fault=1 -> IDLE with fail_count=0, sys_reset=0, lockout=0.
- Outputs:
  - pending = ~seen in RUN; 0 otherwise.
  - kick is never high outside the cycle that follows a done edge.

## Timing
- kick latency: kick is high in the cycle immediately after the edge that samples the final missing heartbeat. It is exactly one cycle wide.
- Timeout latency: RUN is entered at edge E0 with count=PERIOD. With no completion, count reaches 0 at edge E_PERIOD and sys_reset rises at edge E_(PERIOD+1).
- sys_reset high time:
  - exactly HOLD_CYCLES cycles per non-final timeout;
  - continuous from the final timeout until clear_fault is sampled.
- After HOLD, RUN restarts with a fresh window and seen=0. Heartbeats that arrived during HOLD are lost.
- Asynchronous reset in any state (including mid-HOLD or LOCKOUT): all outputs drop to their reset values without waiting for a clock edge. The block returns to IDLE.
- fail_count wrap-around is forbidden: it saturates at MAX_RESETS.
- count never underflows below 0.

## Test plan
The bench uses default parameters throughout.
1. Reset check: pulse reset -> kick=sys_reset=lockout=0, count=30, fail_count=0, pending=0, state IDLE.
2. Staggered completion: enable=1, then pulse heartbeat bits 0,1,2,3 on cycles 5,10,15,20 after RUN entry.
   - pending steps 1111 -> 1110 -> 1100 -> 1000.
   - kick=1 for exactly the one cycle after the bit-3 sample.
   - count reloads to 30 and pending returns to 1111.
3. Simultaneous heartbeats: heartbeat=4'b1111 for a single cycle -> kick on the next cycle. Separately, completion on the cycle where count==0 -> kick and no sys_reset.
4. Partial check-in: only bits 0-2 ever pulse.
   - sys_reset rises at the 31st edge after RUN entry and stays high 8 cycles; fail_count=1.
   - RUN resumes with count=30.
   - A subsequent full check-in kicks and clears fail_count to 0.
5. Lockout: no heartbeats at all.
   - After the third timeout, lockout=1 and sys_reset stays high past 8 cycles.
   - Heartbeats and enable toggles have no effect.
   - clear_fault=1 -> next cycle IDLE, all outputs 0, fail_count=0.
6. Reset mid-operation: assert reset asynchronously mid-HOLD (between clock edges) -> sys_reset falls before the next edge. After release, state is IDLE with fail_count=0.
